// File: rtl/mem_bus_arbiter_if.sv
// Bundle of the fetch port, data port and shared memory port signals around the arbiter.
// The slave modport is the arbiter's view; master is the view of the requesters and memory.
interface mem_bus_arbiter_if;
   logic        halt;

   // Fetch port
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_ack;
   logic        stall_if;

   // Data port
   logic        da_req;
   logic        da_read_wrn;
   logic [15:0] da_addr;
   logic [31:0] da_wdata;
   logic [31:0] da_rdata;
   logic        da_ack;
   logic        stall_da;

   // Shared memory port
   logic        mem_req;
   logic        mem_read_wrn;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic        bus_err;

   modport slave (
      input  halt,
      input  if_req, if_addr,
      output if_rdata, if_ack, stall_if,
      input  da_req, da_read_wrn, da_addr, da_wdata,
      output da_rdata, da_ack, stall_da,
      output mem_req, mem_read_wrn, mem_addr, mem_wdata, bus_err,
      input  mem_rdata, mem_ready
   );

   modport master (
      output halt,
      output if_req, if_addr,
      input  if_rdata, if_ack, stall_if,
      output da_req, da_read_wrn, da_addr, da_wdata,
      input  da_rdata, da_ack, stall_da,
      input  mem_req, mem_read_wrn, mem_addr, mem_wdata, bus_err,
      output mem_rdata, mem_ready
   );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-port (fetch / data) arbiter onto one shared memory bus. Data accesses have priority
// until the fetch port has waited STARVE_LIMIT data grants; a granted access that sees no
// MEM_READY for TIMEOUT cycles is aborted with BUS_ERR.
module mem_bus_arbiter #(
   parameter int unsigned STARVE_LIMIT = 3,
   parameter int unsigned TIMEOUT      = 15
) (
   input logic              i_ck_ref,
   input logic              int_rst_n,
   mem_bus_arbiter_if.slave io_bus
);

   localparam int unsigned StarveW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
   localparam int unsigned WaitW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIMIT);
   localparam logic [WaitW-1:0]   WaitLast  = WaitW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      StIdle,
      StGrantIf,
      StGrantDa
   } state_t;

   state_t r_state, w_state_d;

   logic               r_mem_req,      w_mem_req_d;
   logic               r_mem_read_wrn, w_mem_read_wrn_d;
   logic [31:0]        r_mem_addr,     w_mem_addr_d;
   logic [31:0]        r_mem_wdata,    w_mem_wdata_d;
   logic [31:0]        r_if_rdata,     w_if_rdata_d;
   logic [31:0]        r_da_rdata,     w_da_rdata_d;
   logic               r_if_ack,       w_if_ack_d;
   logic               r_da_ack,       w_da_ack_d;
   logic               r_bus_err,      w_bus_err_d;
   logic [StarveW-1:0] r_starve_cnt,   w_starve_cnt_d;
   logic [WaitW-1:0]   r_wait_cnt,     w_wait_cnt_d;

   // A port's REQ is still high during its own ACK cycle; it must not win a second grant.
   logic w_if_req_eff;
   logic w_da_req_eff;
   logic w_timeout;

   assign w_if_req_eff = io_bus.if_req & ~r_if_ack;
   assign w_da_req_eff = io_bus.da_req & ~r_da_ack;
   assign w_timeout    = (r_wait_cnt == WaitLast);

   // FSM state register
   always_ff @(posedge i_ck_ref or negedge int_rst_n) begin
      if (!int_rst_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_d;
      end
   end

   // Next-state, arbitration and transfer completion
   always_comb begin
      w_state_d        = r_state;
      w_mem_req_d      = r_mem_req;
      w_mem_read_wrn_d = r_mem_read_wrn;
      w_mem_addr_d     = r_mem_addr;
      w_mem_wdata_d    = r_mem_wdata;
      w_if_rdata_d     = r_if_rdata;
      w_da_rdata_d     = r_da_rdata;
      w_if_ack_d       = 1'b0;
      w_da_ack_d       = 1'b0;
      w_bus_err_d      = 1'b0;
      w_starve_cnt_d   = r_starve_cnt;
      w_wait_cnt_d     = r_wait_cnt;

      unique case (r_state)
         StIdle: begin
            // HALT freezes arbitration, including the starvation count
            if (!io_bus.halt) begin
               if (!io_bus.if_req) begin
                  w_starve_cnt_d = '0;
               end
               if (w_da_req_eff && (r_starve_cnt < StarveMax)) begin
                  w_state_d        = StGrantDa;
                  w_mem_req_d      = 1'b1;
                  w_mem_read_wrn_d = io_bus.da_read_wrn;
                  w_mem_addr_d     = {16'h0000, io_bus.da_addr};
                  w_mem_wdata_d    = io_bus.da_wdata;
                  w_wait_cnt_d     = '0;
                  if (io_bus.if_req && (r_starve_cnt != StarveMax)) begin
                     w_starve_cnt_d = r_starve_cnt + 1'b1;
                  end
               end else if (w_if_req_eff) begin
                  w_state_d        = StGrantIf;
                  w_mem_req_d      = 1'b1;
                  w_mem_read_wrn_d = 1'b1;
                  w_mem_addr_d     = io_bus.if_addr;
                  w_wait_cnt_d     = '0;
                  w_starve_cnt_d   = '0;
               end
            end
         end

         StGrantIf, StGrantDa: begin
            if (!io_bus.if_req) begin
               w_starve_cnt_d = '0;
            end
            if (io_bus.mem_ready) begin
               w_state_d   = StIdle;
               w_mem_req_d = 1'b0;
               if (r_state == StGrantIf) begin
                  w_if_ack_d   = 1'b1;
                  w_if_rdata_d = io_bus.mem_rdata;
               end else begin
                  w_da_ack_d = 1'b1;
                  // A completed write leaves the last read result in place
                  if (r_mem_read_wrn) begin
                     w_da_rdata_d = io_bus.mem_rdata;
                  end
               end
            end else if (w_timeout) begin
               w_state_d   = StIdle;
               w_mem_req_d = 1'b0;
               w_bus_err_d = 1'b1;
               if (r_state == StGrantIf) begin
                  w_if_ack_d   = 1'b1;
                  w_if_rdata_d = '0;
               end else begin
                  w_da_ack_d   = 1'b1;
                  w_da_rdata_d = '0;
               end
            end else begin
               w_wait_cnt_d = r_wait_cnt + 1'b1;
            end
         end

         default: begin
            w_state_d   = StIdle;
            w_mem_req_d = 1'b0;
         end
      endcase
   end

   // Bus, data and counter registers
   always_ff @(posedge i_ck_ref or negedge int_rst_n) begin
      if (!int_rst_n) begin
         r_mem_req      <= 1'b0;
         r_mem_read_wrn <= 1'b1;
         r_mem_addr     <= '0;
         r_mem_wdata    <= '0;
         r_if_rdata     <= '0;
         r_da_rdata     <= '0;
         r_if_ack       <= 1'b0;
         r_da_ack       <= 1'b0;
         r_bus_err      <= 1'b0;
         r_starve_cnt   <= '0;
         r_wait_cnt     <= '0;
      end else begin
         r_mem_req      <= w_mem_req_d;
         r_mem_read_wrn <= w_mem_read_wrn_d;
         r_mem_addr     <= w_mem_addr_d;
         r_mem_wdata    <= w_mem_wdata_d;
         r_if_rdata     <= w_if_rdata_d;
         r_da_rdata     <= w_da_rdata_d;
         r_if_ack       <= w_if_ack_d;
         r_da_ack       <= w_da_ack_d;
         r_bus_err      <= w_bus_err_d;
         r_starve_cnt   <= w_starve_cnt_d;
         r_wait_cnt     <= w_wait_cnt_d;
      end
   end

   assign io_bus.mem_req      = r_mem_req;
   assign io_bus.mem_read_wrn = r_mem_read_wrn;
   assign io_bus.mem_addr     = r_mem_addr;
   assign io_bus.mem_wdata    = r_mem_wdata;
   assign io_bus.if_rdata     = r_if_rdata;
   assign io_bus.da_rdata     = r_da_rdata;
   assign io_bus.if_ack       = r_if_ack;
   assign io_bus.da_ack       = r_da_ack;
   assign io_bus.bus_err      = r_bus_err;
   assign io_bus.stall_if     = io_bus.if_req & ~r_if_ack;
   assign io_bus.stall_da     = io_bus.da_req & ~r_da_ack;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter. Expected grants and ACKs are queued when stimulus is
// issued; a monitor on the falling edge pops and compares them as the DUT presents them.
module tb_mem_bus_arbiter;

   logic ck_ref;
   logic int_rst_n;

   mem_bus_arbiter_if bus ();

   mem_bus_arbiter #(
      .STARVE_LIMIT (3),
      .TIMEOUT      (15)
   ) u_dut (
      .i_ck_ref  (ck_ref),
      .int_rst_n (int_rst_n),
      .io_bus    (bus)
   );

   initial ck_ref = 1'b0;
   always #5 ck_ref = ~ck_ref;

   int total = 0;
   int bad   = 0;

   // Memory model: READY after ready_delay cycles of MEM_REQ, data is address ^ A5A50000
   int ready_delay = 0;
   bit never_ready = 1'b0;
   int mem_cnt     = 0;

   always @(posedge ck_ref) mem_cnt <= bus.mem_req ? mem_cnt + 1 : 0;
   assign bus.mem_ready = ~never_ready & (mem_cnt >= ready_delay);
   assign bus.mem_rdata = bus.mem_addr ^ 32'hA5A5_0000;

   typedef struct {
      logic [31:0] addr;
      logic        rd;
      logic [31:0] wdata;
      bit          chk_wd;
   } grant_t;

   typedef struct {
      bit          is_da;
      logic [31:0] rdata;
      logic        err;
   } ack_t;

   grant_t grant_q[$];
   ack_t   ack_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_grant(input logic [31:0] addr, input logic rd, input logic [31:0] wd,
                             input bit chk_wd);
      grant_t g;
      g.addr   = addr;
      g.rd     = rd;
      g.wdata  = wd;
      g.chk_wd = chk_wd;
      grant_q.push_back(g);
   endtask

   task automatic push_ack(input bit is_da, input logic [31:0] rdata, input logic err);
      ack_t a;
      a.is_da = is_da;
      a.rdata = rdata;
      a.err   = err;
      ack_q.push_back(a);
   endtask

   // Monitor: a rising MEM_REQ is a new grant; any ACK completes the oldest expected transfer
   logic prev_mem_req = 1'b0;

   always @(negedge ck_ref) begin
      if (bus.mem_req && !prev_mem_req) begin
         if (grant_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL grant_unexpected actual=%h required=none", bus.mem_addr);
         end else begin
            chk("grant_addr", bus.mem_addr, grant_q[0].addr);
            chk("grant_dir", 32'(bus.mem_read_wrn), 32'(grant_q[0].rd));
            if (grant_q[0].chk_wd) chk("grant_wdata", bus.mem_wdata, grant_q[0].wdata);
            void'(grant_q.pop_front());
         end
      end
      prev_mem_req <= bus.mem_req;

      if (bus.if_ack || bus.da_ack) begin
         if (ack_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL ack_unexpected actual=if%0b/da%0b required=none",
                     bus.if_ack, bus.da_ack);
         end else begin
            chk("ack_port", 32'({bus.da_ack, bus.if_ack}), ack_q[0].is_da ? 32'd2 : 32'd1);
            chk("ack_rdata", ack_q[0].is_da ? bus.da_rdata : bus.if_rdata, ack_q[0].rdata);
            chk("ack_err", 32'(bus.bus_err), 32'(ack_q[0].err));
            void'(ack_q.pop_front());
         end
      end
   end

   // Count falling edges until the port's ACK (bounded); STALL must track REQ & !ACK
   task automatic wait_ack(input bit is_da, input int limit, input int exp_n,
                           input string name);
      int  n    = 0;
      bit  seen = 1'b0;
      logic ack;
      logic stall;
      while (!seen && n < limit) begin
         @(negedge ck_ref);
         n++;
         ack   = is_da ? bus.da_ack : bus.if_ack;
         stall = is_da ? bus.stall_da : bus.stall_if;
         if (ack) seen = 1'b1;
         chk("stall", 32'(stall), 32'(!ack));
      end
      if (!seen) n = -1;
      chk(name, n, exp_n);
      @(posedge ck_ref);
      #1;
   endtask

   initial begin
      #100000;
      bad++;
      $display("FAIL watchdog actual=running required=finished");
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      int_rst_n          = 1'b0;
      bus.halt           = 1'b0;
      bus.if_req         = 1'b0;
      bus.if_addr        = '0;
      bus.da_req         = 1'b0;
      bus.da_read_wrn    = 1'b1;
      bus.da_addr        = '0;
      bus.da_wdata       = '0;

      // Reset state
      repeat (2) @(negedge ck_ref);
      chk("rst_mem_req", 32'(bus.mem_req), 0);
      chk("rst_mem_dir", 32'(bus.mem_read_wrn), 1);
      chk("rst_acks", 32'({bus.if_ack, bus.da_ack, bus.bus_err}), 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_mem_wdata", bus.mem_wdata, 0);
      chk("rst_if_rdata", bus.if_rdata, 0);
      chk("rst_da_rdata", bus.da_rdata, 0);
      #2 int_rst_n = 1'b1;

      // Minimum-latency fetch
      @(posedge ck_ref);
      #1;
      ready_delay = 0;
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h0000_0100;
      push_grant(32'h0000_0100, 1'b1, '0, 1'b0);
      push_ack(1'b0, 32'hA5A5_0100, 1'b0);
      @(negedge ck_ref);
      chk("if_cycle0_mem_req", 32'(bus.mem_req), 0);
      @(negedge ck_ref);
      chk("if_cycle1_mem_req", 32'(bus.mem_req), 1);
      chk("if_cycle1_mem_addr", bus.mem_addr, 32'h0000_0100);
      @(negedge ck_ref);
      chk("if_cycle2_ack", 32'(bus.if_ack), 1);
      chk("if_cycle2_rdata", bus.if_rdata, 32'hA5A5_0100);
      @(posedge ck_ref);
      #1 bus.if_req = 1'b0;

      // Data read, one wait cycle
      ready_delay     = 1;
      bus.da_req      = 1'b1;
      bus.da_read_wrn = 1'b1;
      bus.da_addr     = 16'h0040;
      push_grant(32'h0000_0040, 1'b1, '0, 1'b0);
      push_ack(1'b1, 32'hA5A5_0040, 1'b0);
      wait_ack(1'b1, 10, 4, "da_read_latency");
      bus.da_req = 1'b0;

      // Data write, READY in the 4th granted cycle; DA_RDATA keeps the last read
      ready_delay     = 3;
      bus.da_req      = 1'b1;
      bus.da_read_wrn = 1'b0;
      bus.da_addr     = 16'h00F0;
      bus.da_wdata    = 32'hDEAD_BEEF;
      push_grant(32'h0000_00F0, 1'b0, 32'hDEAD_BEEF, 1'b1);
      push_ack(1'b1, 32'hA5A5_0040, 1'b0);
      wait_ack(1'b1, 12, 6, "da_write_latency");
      bus.da_req = 1'b0;
      @(negedge ck_ref);
      chk("da_rdata_hold", bus.da_rdata, 32'hA5A5_0040);
      @(posedge ck_ref);
      #1;

      // Timeout: ACK with BUS_ERR after 15 granted cycles without READY
      never_ready     = 1'b1;
      bus.da_req      = 1'b1;
      bus.da_read_wrn = 1'b1;
      bus.da_addr     = 16'h1234;
      push_grant(32'h0000_1234, 1'b1, '0, 1'b0);
      push_ack(1'b1, 32'h0000_0000, 1'b1);
      wait_ack(1'b1, 30, 17, "timeout_latency");
      bus.da_req  = 1'b0;
      never_ready = 1'b0;
      @(negedge ck_ref);
      chk("timeout_idle_mem_req", 32'(bus.mem_req), 0);
      chk("timeout_err_pulse", 32'(bus.bus_err), 0);
      @(posedge ck_ref);
      #1;

      // HALT during a fetch: fetch completes, pending data request waits for HALT=0
      ready_delay = 2;
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h0000_0200;
      push_grant(32'h0000_0200, 1'b1, '0, 1'b0);
      push_ack(1'b0, 32'hA5A5_0200, 1'b0);
      push_grant(32'h0000_0080, 1'b1, '0, 1'b0);
      push_ack(1'b1, 32'hA5A5_0080, 1'b0);
      @(posedge ck_ref);
      #1;
      bus.halt        = 1'b1;
      bus.da_req      = 1'b1;
      bus.da_read_wrn = 1'b1;
      bus.da_addr     = 16'h0080;
      wait_ack(1'b0, 10, 4, "halt_if_latency");
      bus.if_req  = 1'b0;
      ready_delay = 0;
      repeat (4) begin
         @(negedge ck_ref);
         chk("halt_no_grant", 32'(bus.mem_req), 0);
         chk("halt_no_da_ack", 32'(bus.da_ack), 0);
      end
      @(posedge ck_ref);
      #1 bus.halt = 1'b0;
      wait_ack(1'b1, 10, 3, "halt_release_latency");
      bus.da_req = 1'b0;

      // Starvation: HALT covers each DA ACK cycle so the fetch port cannot take it, letting
      // DA re-request; the 4th grant must go to the waiting fetch.
      ready_delay     = 0;
      bus.halt        = 1'b1;
      bus.if_req      = 1'b1;
      bus.if_addr     = 32'h0000_0300;
      bus.da_req      = 1'b1;
      bus.da_read_wrn = 1'b1;
      bus.da_addr     = 16'h0010;
      push_grant(32'h0000_0010, 1'b1, '0, 1'b0);
      push_ack(1'b1, 32'hA5A5_0010, 1'b0);
      push_grant(32'h0000_0020, 1'b1, '0, 1'b0);
      push_ack(1'b1, 32'hA5A5_0020, 1'b0);
      push_grant(32'h0000_0030, 1'b1, '0, 1'b0);
      push_ack(1'b1, 32'hA5A5_0030, 1'b0);
      push_grant(32'h0000_0300, 1'b1, '0, 1'b0);
      push_ack(1'b0, 32'hA5A5_0300, 1'b0);
      push_grant(32'h0000_0040, 1'b1, '0, 1'b0);
      push_ack(1'b1, 32'hA5A5_0040, 1'b0);
      for (int i = 0; i < 5; i++) begin
         bit seen;
         @(posedge ck_ref);
         #1 bus.halt = 1'b0;
         @(posedge ck_ref);
         #1 bus.halt = 1'b1;
         seen = 1'b0;
         for (int c = 0; c < 8 && !seen; c++) begin
            @(negedge ck_ref);
            if (bus.if_ack || bus.da_ack) seen = 1'b1;
         end
         chk("starve_ack_seen", 32'(seen), 1);
         if (bus.da_ack) bus.da_addr = bus.da_addr + 16'h0010;
         @(posedge ck_ref);
         #1;
         if (i == 3) bus.if_req = 1'b0;
         if (i == 4) bus.da_req = 1'b0;
      end
      bus.halt = 1'b0;

      // Reset in the middle of a data grant drops it with no ACK; the request is re-served
      ready_delay     = 5;
      bus.da_req      = 1'b1;
      bus.da_read_wrn = 1'b1;
      bus.da_addr     = 16'h0500;
      push_grant(32'h0000_0500, 1'b1, '0, 1'b0);
      repeat (3) @(negedge ck_ref);
      chk("rst_mid_granted", 32'(bus.mem_req), 1);
      #2 int_rst_n = 1'b0;
      #1;
      chk("rst_mid_mem_req", 32'(bus.mem_req), 0);
      chk("rst_mid_da_ack", 32'(bus.da_ack), 0);
      chk("rst_mid_mem_addr", bus.mem_addr, 0);
      chk("rst_mid_mem_dir", 32'(bus.mem_read_wrn), 1);
      chk("rst_mid_da_rdata", bus.da_rdata, 0);
      repeat (2) @(negedge ck_ref);
      ready_delay = 0;
      push_grant(32'h0000_0500, 1'b1, '0, 1'b0);
      push_ack(1'b1, 32'hA5A5_0500, 1'b0);
      #2 int_rst_n = 1'b1;
      wait_ack(1'b1, 10, 2, "rst_reserve_latency");
      bus.da_req = 1'b0;

      repeat (5) @(negedge ck_ref);
      chk("grant_q_drained", grant_q.size(), 0);
      chk("ack_q_drained", ack_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 3: consecutive data-port grants tolerated while the fetch port waits.
REQ-002 SHALL have parameter TIMEOUT, default 15: granted cycles without MEM_READY before abort.
REQ-003 CK_REF  in  1  clock, all state updates on rising edge.
REQ-004 int_rst_n  in  1  reset, asynchronous, active-low.
REQ-005 HALT  in  1  blocks new grants; an in-flight transfer completes.
REQ-006 IF_REQ  in  1  fetch request, held until IF_ACK.
REQ-007 IF_ADDR  in  32  fetch address.
REQ-008 IF_RDATA  out  32  fetch read data, valid while IF_ACK=1.
REQ-009 IF_ACK  out  1  one-cycle fetch completion pulse.
REQ-010 DA_REQ  in  1  data-access request, held until DA_ACK.
REQ-011 DA_READ_WRN  in  1  1=read, 0=write.
REQ-012 DA_ADDR  in  16  data address.
REQ-013 DA_WDATA  in  32  write data.
REQ-014 DA_RDATA  out  32  data read result, valid while DA_ACK=1.
REQ-015 DA_ACK  out  1  one-cycle data completion pulse.
REQ-016 MEM_REQ  out  1  shared memory request, registered.
REQ-017 MEM_READ_WRN  out  1  shared memory direction, registered.
REQ-018 MEM_ADDR  out  32  shared memory address, registered.
REQ-019 MEM_WDATA  out  32  shared memory write data, registered.
REQ-020 MEM_RDATA  in  32  shared memory read data.
REQ-021 MEM_READY  in  1  memory completes the current access at this edge.
REQ-022 BUS_ERR  out  1  one-cycle timeout pulse, coincident with the ACK.
REQ-023 STALL_IF / STALL_DA  out  1 each  combinational: REQ=1 and ACK=0 for that port.

Function
REQ-024 FSM states SHALL be IDLE, GRANT_IF, GRANT_DA; only IDLE issues grants.
REQ-025 In IDLE, with HALT=0, at the rising edge: DA_REQ=1 and starve_cnt<STARVE_LIMIT -> GRANT_DA; otherwise IF_REQ=1 -> GRANT_IF; no request -> stay IDLE.
REQ-026 On grant, address, direction and write data SHALL be latched; MEM_REQ=1 from the next cycle.
REQ-027 Latching SHALL be: DA_ADDR zero-extended to 32 bits; a fetch always uses MEM_READ_WRN=1.
REQ-028 In GRANT_x with MEM_READY=1 at the edge: MEM_RDATA captured into x_RDATA, x_ACK=1 for the following cycle, MEM_REQ=0, state -> IDLE.
REQ-029 Minimum latency SHALL be 2 cycles: REQ sampled at edge 0, MEM_REQ high cycle 1, ACK high cycle 2 when MEM_READY is high in cycle 1.
REQ-030 During the cycle its ACK is high, the acked port's REQ SHALL be ignored for arbitration; the other port may be granted at that edge.
REQ-031 starve_cnt (saturating at STARVE_LIMIT) SHALL increment on each DA grant while IF_REQ=1 and clear on an IF grant or whenever IF_REQ=0.
REQ-032 At starve_cnt=STARVE_LIMIT, a pending IF SHALL win over DA.
REQ-033 wait_cnt SHALL clear on grant and increment each granted cycle with MEM_READY=0.
REQ-034 When wait_cnt reaches TIMEOUT-1 with MEM_READY=0: x_ACK=1, BUS_ERR=1, x_RDATA=0, MEM_REQ=0, state -> IDLE.
REQ-035 HALT asserted in GRANT_x SHALL NOT abort the transfer; HALT in IDLE holds IDLE and holds starve_cnt.
REQ-036 x_RDATA SHALL hold its last value outside ACK cycles; writes leave DA_RDATA unchanged.

Reset
REQ-037 On int_rst_n=0, all outputs SHALL immediately go to 0: MEM_REQ, IF_ACK, DA_ACK, BUS_ERR, MEM_ADDR, MEM_WDATA, IF_RDATA, DA_RDATA.
REQ-038 On int_rst_n=0, MEM_READ_WRN SHALL go to 1, the FSM to IDLE, and starve_cnt and wait_cnt to 0.
REQ-039 Reset mid-transfer SHALL drop the transfer with no ACK; requesters re-issue after reset release.

Verification
REQ-040 IF_REQ=1, IF_ADDR=0x100, MEM_READY=1 always -> MEM_REQ high cycle 1 with MEM_ADDR=0x100; IF_ACK high cycle 2 with IF_RDATA=MEM_RDATA.
REQ-041 IF_REQ and DA_REQ both held, DA re-requested immediately after each ack, STARVE_LIMIT=3 -> grant order DA,DA,DA,IF,DA...
REQ-042 DA write, DA_ADDR=0x00F0, DA_WDATA=0xDEADBEEF, MEM_READY after 4 cycles -> MEM_READ_WRN=0, MEM_ADDR=0x000000F0, DA_ACK 1 cycle, DA_RDATA unchanged.
REQ-043 DA read with MEM_READY never high -> at the 15th granted cycle DA_ACK=1, BUS_ERR=1, DA_RDATA=0; FSM returns to IDLE.
REQ-044 HALT raised during GRANT_IF -> transfer completes; a pending DA_REQ is not granted until HALT=0.
REQ-045 int_rst_n pulsed low in GRANT_DA -> MEM_REQ=0 immediately, no DA_ACK; after release, DA re-served normally.
